// File: rtl/cs_window_filter.sv
// Sliding-window "approximate average" noise filter: Y = (sum + N*Xappr) >> SHIFT.
// Optional output saturation when CS_WINDOW_SAT_EN is defined (default: modulo truncation).
module cs_window_filter #(
  parameter int DW    = 8,
  parameter int N     = 9,
  parameter int SHIFT = 3,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] X,
  input  logic          x_valid,
  output logic [YW-1:0] Y,
  output logic          y_valid
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int SW = DW + CW;
  localparam int W  = SW + $clog2(N) + 1;

  localparam logic [W-1:0]  NW   = W'(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  logic [DW-1:0] r_buf [N];
  logic [SW-1:0] r_sum;
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [YW-1:0] r_y_p1;
  logic          r_vld_p1;

  logic [SW-1:0] w_sum_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_full;
  logic [DW-1:0] w_samp;
  logic [DW-1:0] w_xappr;
  logic [W-1:0]  w_yfull;

  function automatic logic [YW-1:0] f_fit(input logic [W-1:0] v);
`ifdef CS_WINDOW_SAT_EN
    if ((v >> YW) != '0) return '1;
    return YW'(v);
`else
    return YW'(v);
`endif
  endfunction

  // The outgoing entry is zero during fill, so the sum stays exact from reset on.
  assign w_sum_next = r_sum + SW'(X) - SW'(r_buf[r_ptr]);
  assign w_cnt_next = (r_cnt == FULL) ? FULL : r_cnt + CW'(1);
  assign w_full     = (w_cnt_next == FULL);

  // N*s <= sum selects samples not above floor(mean) without a divider.
  always_comb begin
    w_xappr = '0;
    w_samp  = '0;
    for (int i = 0; i < N; i++) begin
      w_samp = (i == int'(r_ptr)) ? X : r_buf[i];
      if (((NW * W'(w_samp)) <= W'(w_sum_next)) && (w_samp > w_xappr))
        w_xappr = w_samp;
    end
  end

  assign w_yfull = (W'(w_sum_next) + NW * W'(w_xappr)) >> SHIFT;

  // Stage p1: window update and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_sum    <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_y_p1   <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (x_valid) begin
        r_buf[r_ptr] <= X;
        r_sum        <= w_sum_next;
        r_ptr        <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
        r_cnt        <= w_cnt_next;
        if (w_full) begin
          r_y_p1   <= f_fit(w_yfull);
          r_vld_p1 <= 1'b1;
        end
      end
    end
  end

  assign Y       = r_y_p1;
  assign y_valid = r_vld_p1;

endmodule
